csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file. It is the responder side of the execution unit's CSR
//  read/write port: reads are combinational, writes commit on the clock edge.
//  Owns trap entry and mret. Drives the one-cycle csr_branch/csr_branch_pc redirect
//  consumed by the EX0 branch unit. Sits beside the commit stage.
// PARAMETERS
//  CSR_ADDR_WIDTH  20          width of csr_address; only bits [11:0] are decoded
//  RESET_MTVEC     32'h0000_0100  reset value of mtvec
// PORTS
//  clk            in   1              clock
//  rst_n          in   1              reset, asynchronous, active-low
//  csr_address    in   CSR_ADDR_WIDTH CSR index from the execution unit
//  csr_data       out  32             combinational read data for csr_address
//  csr_wr_en      in   1              write strobe
//  csr_wr_data    in   32             write data, already merged (set/clear) by requester
//  commit_cnt     in   2              instructions retired this cycle (0..2)
//  trap_valid     in   1              exception taken at commit
//  trap_pc        in   32             pc of the faulting instruction
//  trap_cause     in   5              exception cause code
//  mret_valid     in   1              mret retired
//  csr_branch     out  1              redirect pulse, registered
//  csr_branch_pc  out  32             redirect target, registered
// BEHAVIOUR
//  Address map (addr[11:0]); unmapped: read 0, write ignored, no error:
//   0x300 mstatus: MIE=b3, MPIE=b7 writable; MPP b12:11 reads 2'b11; other bits read 0
//   0x305 mtvec: bits[1:0] read 0 (direct mode only)
//   0x340 mscratch: all 32 bits RW
//   0x341 mepc: bit0 reads 0
//   0x342 mcause: {27'b0,cause}; writes keep [4:0]
//   0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi (RW)
//   0xC00/0xC80/0xC02/0xC82 read-only aliases of the counters; writes ignored
//  Reset (async): mstatus=0x1800, mtvec=RESET_MTVEC, mscratch=0, mepc=0, mcause=0,
//   counters=0, csr_branch=0, csr_branch_pc=0, FSM=IDLE.
//  Reads: csr_data = f(csr_address, current state). Same-cycle write not forwarded.
//  Writes: the target register updates at the next posedge.
//  Counters: 64-bit, free-running; mcycle +1/cycle; minstret +commit_cnt; wrap 2^64-1 -> 0.
//   A write to either half replaces that half only. Carry from the old low half into
//   the high half is suppressed in that cycle.
//  FSM IDLE/REDIRECT:
//   IDLE & trap_valid: mepc<=trap_pc&~1; mcause<=trap_cause; MPIE<=MIE; MIE<=0.
//    Next cycle: REDIRECT, csr_branch=1, csr_branch_pc=mtvec as it was before the edge.
//   IDLE & mret_valid & !trap_valid: MIE<=MPIE; MPIE<=1.
//    Next cycle: REDIRECT, csr_branch=1, csr_branch_pc=mepc as it was before the edge.
//   REDIRECT -> IDLE unconditionally; csr_branch=0.
//    trap_valid/mret_valid are ignored in REDIRECT (the pipeline is flushing).
//    csr_wr_en and counters remain live.
//  Priority in one cycle: trap > mret > csr write to the same field (the write is dropped).
//   A write to an unrelated CSR in the same cycle still commits.
//  Reset asserted mid-REDIRECT: outputs clear immediately, with no pending redirect.
// CONFIGURATION
//  CSR_COUNTERS_EN defined: mcycle/minstret and their aliases are implemented as above.
//  CSR_COUNTERS_EN undefined: no counter flops; those addresses read 0 and writes are
//   ignored; commit_cnt is unused.
// TESTING
//  T1 reset: release rst_n; read 0x300 -> 0x1800, 0x305 -> 0x100, 0xB00 -> 1 cycle later
//   counts 1,2,3...
//  T2 RW masks: write 0xFFFF_FFFF to 0x300/0x305/0x341 -> reads 0x1888/0xFFFF_FFFC/0xFFFF_FFFE.
//   Write 0x342 -> 0x1F.
//  T3 trap: mtvec=0x200, MIE=1, trap_valid, trap_pc=0x1235, cause=2 -> next cycle
//   csr_branch=1, pc=0x200; mepc=0x1234, mcause=2, mstatus=0x1880; cycle after csr_branch=0.
//  T4 mret: after T3, mret_valid -> next cycle csr_branch=1, pc=0x1234, mstatus=0x1888.
//   mret in REDIRECT cycle -> no action.
//  T5 collision: trap_valid + csr_wr_en to 0x341 with 0xDEAD0000 same cycle -> mepc=trap_pc.
//   trap + mret same cycle -> target mtvec.
//  T6 counters: write 0xFFFF_FFFF to 0xB02, commit_cnt=2 next cycle -> lo=1, hi=1.
//   0xC00 write ignored. With CSR_COUNTERS_EN undefined, 0xB00 reads 0.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file beside the commit stage.
//   Responds to the execution unit's CSR port (combinational read, clocked write),
//   owns trap entry and mret, and issues the one-cycle csr_branch redirect.
// Configuration macro: CSR_COUNTERS_EN enables mcycle/minstret (0xB00/0xB80/0xB02/0xB82)
//   and their read-only aliases (0xC00/0xC80/0xC02/0xC82). Without it those
//   addresses read 0, writes are ignored and commit_cnt is unused.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   csr_address / csr_data      CSR index in, combinational read data out
//   csr_wr_en / csr_wr_data     write strobe and merged write data
//   commit_cnt                  instructions retired this cycle (0..2)
//   trap_valid/pc/cause         exception taken at commit
//   mret_valid                  mret retired
//   csr_branch / csr_branch_pc  registered one-cycle redirect to EX0
module csr_file #(
   parameter int unsigned CSR_ADDR_WIDTH = 20,
   parameter logic [31:0] RESET_MTVEC    = 32'h0000_0100
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
   output logic [31:0]               csr_data,
   input  logic                      csr_wr_en,
   input  logic [31:0]               csr_wr_data,
   input  logic [1:0]                commit_cnt,
   input  logic                      trap_valid,
   input  logic [31:0]               trap_pc,
   input  logic [4:0]                trap_cause,
   input  logic                      mret_valid,
   output logic                      csr_branch,
   output logic [31:0]               csr_branch_pc
);

   localparam int unsigned DEC_W = 12;

   typedef enum logic {IDLE, REDIRECT} state_e;

   state_e      state_q, state_d;
   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic [31:2] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:1] mepc_q, mepc_d;
   logic [4:0]  mcause_q, mcause_d;
   logic        branch_q, branch_d;
   logic [31:0] branch_pc_q, branch_pc_d;

   logic [DEC_W-1:0] addr;
   logic             unused_addr_hi;
   assign addr           = csr_address[DEC_W-1:0];
   assign unused_addr_hi = ^csr_address[CSR_ADDR_WIDTH-1:DEC_W];

   // Architectural views of the stored fields
   logic [31:0] mstatus_rd, mtvec_rd, mepc_rd;
   assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
   assign mtvec_rd   = {mtvec_q, 2'b00};
   assign mepc_rd    = {mepc_q, 1'b0};

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

   // Free-running counters; a half-write replaces that half and drops the carry into hi
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + 64'(commit_cnt);
      if (csr_wr_en && addr == 12'hB00) mcycle_d = {mcycle_q[63:32], csr_wr_data};
      else if (csr_wr_en && addr == 12'hB80) mcycle_d[63:32] = csr_wr_data;
      if (csr_wr_en && addr == 12'hB02) minstret_d = {minstret_q[63:32], csr_wr_data};
      else if (csr_wr_en && addr == 12'hB82) minstret_d[63:32] = csr_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`else
   logic [1:0] unused_commit_cnt;
   assign unused_commit_cnt = commit_cnt;
`endif

   // Read mux; unmapped addresses return 0
   always_comb begin
      csr_data = 32'h0;
      case (addr)
         12'h300: csr_data = mstatus_rd;
         12'h305: csr_data = mtvec_rd;
         12'h340: csr_data = mscratch_q;
         12'h341: csr_data = mepc_rd;
         12'h342: csr_data = {27'b0, mcause_q};
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hC00: csr_data = mcycle_q[31:0];
         12'hB80, 12'hC80: csr_data = mcycle_q[63:32];
         12'hB02, 12'hC02: csr_data = minstret_q[31:0];
         12'hB82, 12'hC82: csr_data = minstret_q[63:32];
`endif
         default: csr_data = 32'h0;
      endcase
   end

   // Next-state: CSR writes first, then trap/mret override the fields they own
   always_comb begin
      state_d     = state_q;
      branch_d    = 1'b0;
      branch_pc_d = branch_pc_q;
      mie_d       = mie_q;
      mpie_d      = mpie_q;
      mtvec_d     = mtvec_q;
      mscratch_d  = mscratch_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;

      if (csr_wr_en) begin
         case (addr)
            12'h300: begin
               mie_d  = csr_wr_data[3];
               mpie_d = csr_wr_data[7];
            end
            12'h305: mtvec_d    = csr_wr_data[31:2];
            12'h340: mscratch_d = csr_wr_data;
            12'h341: mepc_d     = csr_wr_data[31:1];
            12'h342: mcause_d   = csr_wr_data[4:0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (trap_valid) begin
               state_d     = REDIRECT;
               branch_d    = 1'b1;
               branch_pc_d = mtvec_rd;
               mepc_d      = trap_pc[31:1];
               mcause_d    = trap_cause;
               mpie_d      = mie_q;
               mie_d       = 1'b0;
            end else if (mret_valid) begin
               state_d     = REDIRECT;
               branch_d    = 1'b1;
               branch_pc_d = mepc_rd;
               mie_d       = mpie_q;
               mpie_d      = 1'b1;
            end
         end
         // Pipeline is flushing: trap/mret are ignored for this cycle
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mie_q       <= 1'b0;
         mpie_q      <= 1'b0;
         mtvec_q     <= RESET_MTVEC[31:2];
         mscratch_q  <= '0;
         mepc_q      <= '0;
         mcause_q    <= '0;
         branch_q    <= 1'b0;
         branch_pc_q <= '0;
      end else begin
         state_q     <= state_d;
         mie_q       <= mie_d;
         mpie_q      <= mpie_d;
         mtvec_q     <= mtvec_d;
         mscratch_q  <= mscratch_d;
         mepc_q      <= mepc_d;
         mcause_q    <= mcause_d;
         branch_q    <= branch_d;
         branch_pc_q <= branch_pc_d;
      end
   end

   assign csr_branch    = branch_q;
   assign csr_branch_pc = branch_pc_q;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed stimulus with a scoreboard for csr_file.
//   Stimulus pushes expected read data and expected redirects into queues; a
//   negedge monitor pops and compares whenever a read is presented or
//   csr_branch pulses.
module tb_csr_file;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] csr_address = '0;
   logic [31:0] csr_data;
   logic        csr_wr_en = 1'b0;
   logic [31:0] csr_wr_data = '0;
   logic [1:0]  commit_cnt = '0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_pc = '0;
   logic [4:0]  trap_cause = '0;
   logic        mret_valid = 1'b0;
   logic        csr_branch;
   logic [31:0] csr_branch_pc;

   csr_file dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .csr_address   (csr_address),
      .csr_data      (csr_data),
      .csr_wr_en     (csr_wr_en),
      .csr_wr_data   (csr_wr_data),
      .commit_cnt    (commit_cnt),
      .trap_valid    (trap_valid),
      .trap_pc       (trap_pc),
      .trap_cause    (trap_cause),
      .mret_valid    (mret_valid),
      .csr_branch    (csr_branch),
      .csr_branch_pc (csr_branch_pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rd_chk = 1'b0;
   logic br_prev = 1'b0;

   logic [31:0] exp_q[$];
   string       nm_q[$];
   int          brc_q[$];
   logic [31:0] brpc_q[$];

   logic [31:0] m_e, m_p;
   string       m_n;
   int          m_c;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare read data and redirect pulses against the queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_chk) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL read_underflow: csr_data=%h with no expectation", csr_data);
            end else begin
               m_e = exp_q.pop_front();
               m_n = nm_q.pop_front();
               if (csr_data !== m_e) begin
                  errors++;
                  $display("FAIL %s: csr_data=%h expected %h", m_n, csr_data, m_e);
               end
            end
         end
         if (csr_branch) begin
            checks++;
            if (br_prev || brc_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_branch: csr_branch=1 pc=%h at cycle %0d", csr_branch_pc, cyc);
            end else begin
               m_c = brc_q.pop_front();
               m_p = brpc_q.pop_front();
               if (m_c != cyc || csr_branch_pc !== m_p) begin
                  errors++;
                  $display("FAIL branch: pc=%h cycle=%0d expected pc=%h cycle=%0d",
                           csr_branch_pc, cyc, m_p, m_c);
               end
            end
         end
         br_prev <= csr_branch;
      end else begin
         br_prev <= 1'b0;
      end
   end

   // One cycle of stimulus, applied just after the posedge
   task automatic drive(input logic [19:0] a, input logic we, input logic [31:0] wd,
                        input logic tv, input logic [31:0] tpc, input logic [4:0] tc,
                        input logic mv, input logic [1:0] cc,
                        input logic chk, input logic [31:0] exp, input string nm,
                        input logic br, input logic [31:0] brpc);
      @(posedge clk);
      #1;
      csr_address = a;
      csr_wr_en   = we;
      csr_wr_data = wd;
      trap_valid  = tv;
      trap_pc     = tpc;
      trap_cause  = tc;
      mret_valid  = mv;
      commit_cnt  = cc;
      rd_chk      = chk;
      if (chk) begin
         exp_q.push_back(exp);
         nm_q.push_back(nm);
      end
      if (br) begin
         brc_q.push_back(cyc + 1);
         brpc_q.push_back(brpc);
      end
   endtask

   task automatic rd(input logic [19:0] a, input logic [31:0] exp, input string nm);
      drive(a, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b1, exp, nm, 1'b0, 32'h0);
   endtask

   task automatic wr(input logic [19:0] a, input logic [31:0] d);
      drive(a, 1'b1, d, 1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, "", 1'b0, 32'h0);
   endtask

   task automatic idle();
      drive(20'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, "", 1'b0, 32'h0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state and first counts
`ifdef CSR_COUNTERS_EN
      rd(20'hB00, 32'd1, "mcycle_1");
      rd(20'hB00, 32'd2, "mcycle_2");
      rd(20'hB00, 32'd3, "mcycle_3");
`else
      rd(20'hB00, 32'd0, "mcycle_absent");
`endif
      rd(20'h300, 32'h0000_1800, "mstatus_reset");
      rd(20'h305, 32'h0000_0100, "mtvec_reset");
      rd(20'h341, 32'h0, "mepc_reset");

      // Write masks, decode of low 12 bits, no same-cycle forwarding
      wr(20'h300, 32'hFFFF_FFFF);  rd(20'h300, 32'h0000_1888, "mstatus_mask");
      wr(20'h305, 32'hFFFF_FFFF);  rd(20'h305, 32'hFFFF_FFFC, "mtvec_mask");
      wr(20'h341, 32'hFFFF_FFFF);  rd(20'h341, 32'hFFFF_FFFE, "mepc_mask");
      wr(20'h342, 32'hFFFF_FFFF);  rd(20'h342, 32'h0000_001F, "mcause_mask");
      wr(20'h340, 32'hA5A5_5A5A);  rd(20'hAB340, 32'hA5A5_5A5A, "mscratch_alias_hi_bits");
      drive(20'h340, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 5'd0, 1'b0, 2'd0,
            1'b1, 32'hA5A5_5A5A, "mscratch_no_forward", 1'b0, 32'h0);
      rd(20'h340, 32'h1234_5678, "mscratch_written");
      wr(20'h123, 32'hFFFF_FFFF);  rd(20'h123, 32'h0, "unmapped");

      // Trap entry
      wr(20'h305, 32'h0000_0200);
      drive(20'h0, 1'b0, 32'h0, 1'b1, 32'h1235, 5'd2, 1'b0, 2'd0,
            1'b0, 32'h0, "", 1'b1, 32'h0000_0200);
      rd(20'h341, 32'h0000_1234, "trap_mepc");
      rd(20'h342, 32'h0000_0002, "trap_mcause");
      rd(20'h300, 32'h0000_1880, "trap_mstatus");

      // mret, then an mret during REDIRECT that must do nothing
      drive(20'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b1, 2'd0,
            1'b0, 32'h0, "", 1'b1, 32'h0000_1234);
      drive(20'h300, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b1, 2'd0,
            1'b1, 32'h0000_1888, "mret_mstatus", 1'b0, 32'h0);
      rd(20'h300, 32'h0000_1888, "mret_ignored");

      // Trap beats a write to mepc; trap during REDIRECT ignored while a write commits
      drive(20'h341, 1'b1, 32'hDEAD_0000, 1'b1, 32'h2000, 5'd5, 1'b0, 2'd0,
            1'b0, 32'h0, "", 1'b1, 32'h0000_0200);
      drive(20'h340, 1'b1, 32'h0000_1111, 1'b1, 32'h3000, 5'd7, 1'b0, 2'd0,
            1'b1, 32'h1234_5678, "redirect_mscratch_old", 1'b0, 32'h0);
      rd(20'h341, 32'h0000_2000, "collision_mepc");
      rd(20'h342, 32'h0000_0005, "redirect_trap_ignored");
      rd(20'h340, 32'h0000_1111, "redirect_write_live");
      rd(20'h300, 32'h0000_1880, "trap2_mstatus");

      // Trap and mret together: trap wins, target is mtvec; unrelated write commits
      drive(20'h340, 1'b1, 32'h0000_2222, 1'b1, 32'h4000, 5'd3, 1'b1, 2'd0,
            1'b0, 32'h0, "", 1'b1, 32'h0000_0200);
      rd(20'h300, 32'h0000_1800, "trap_over_mret_mstatus");
      rd(20'h340, 32'h0000_2222, "trap_unrelated_write");

      // mret beats a write to mstatus
      drive(20'h300, 1'b1, 32'h0, 1'b0, 32'h0, 5'd0, 1'b1, 2'd0,
            1'b0, 32'h0, "", 1'b1, 32'h0000_4000);
      idle();
      rd(20'h300, 32'h0000_1880, "mret_over_write");

      // Counters
`ifdef CSR_COUNTERS_EN
      wr(20'hB02, 32'hFFFF_FFFF);
      drive(20'hB02, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'd2,
            1'b1, 32'hFFFF_FFFF, "minstret_lo_written", 1'b0, 32'h0);
      rd(20'hB02, 32'h0000_0001, "minstret_lo_wrap");
      rd(20'hB82, 32'h0000_0001, "minstret_hi_carry");
      rd(20'hC02, 32'h0000_0001, "minstret_alias");
      wr(20'hB80, 32'h0000_0005);
      wr(20'hB00, 32'hFFFF_FFFE);
      rd(20'hB00, 32'hFFFF_FFFE, "mcycle_lo_written");
      rd(20'hB80, 32'h0000_0005, "mcycle_hi_written");
      drive(20'hC00, 1'b1, 32'h0000_0077, 1'b0, 32'h0, 5'd0, 1'b0, 2'd0,
            1'b1, 32'h0, "mcycle_lo_wrapped", 1'b0, 32'h0);
      rd(20'hB80, 32'h0000_0006, "mcycle_hi_carry");
      rd(20'hC00, 32'h0000_0002, "mcycle_alias_write_ignored");
`else
      wr(20'hB00, 32'hFFFF_FFFF);
      drive(20'hB02, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd0, 1'b0, 2'd2,
            1'b1, 32'h0, "minstret_absent", 1'b0, 32'h0);
      rd(20'hB00, 32'h0, "mcycle_write_ignored");
      rd(20'hB02, 32'h0, "minstret_write_ignored");
      rd(20'hC00, 32'h0, "mcycle_alias_absent");
`endif

      // Reset asserted while the redirect is on the outputs
      drive(20'h0, 1'b0, 32'h0, 1'b1, 32'h5000, 5'd4, 1'b0, 2'd0,
            1'b0, 32'h0, "", 1'b0, 32'h0);
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      trap_valid = 1'b0;
      rd_chk     = 1'b0;
      #1;
      checks++;
      if (csr_branch !== 1'b0 || csr_branch_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_redirect: branch=%b pc=%h expected 0 00000000",
                  csr_branch, csr_branch_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      rd(20'h300, 32'h0000_1800, "mstatus_after_reset");
      rd(20'h341, 32'h0, "mepc_after_reset");
      rd(20'h305, 32'h0000_0100, "mtvec_after_reset");
      repeat (3) idle();
      @(negedge clk);

      checks++;
      if (exp_q.size() != 0 || brc_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d reads and %0d redirects never observed",
                  exp_q.size(), brc_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
